mesa_word2ascii: RTL and testbench

MESA_WORD2ASCII -- requirements
Module: mesa_word2ascii

---
 rtl/mesa_word2ascii_pkg.sv | 33 +++
 rtl/mesa_word2ascii_if.sv | 29 ++
 rtl/mesa_tx_fifo.sv | 46 ++++
 rtl/mesa_word2ascii.sv | 168 ++++++++++++++++
 tb/tb_mesa_word2ascii.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mesa_word2ascii_pkg.sv
// Shared definitions for the word-to-ASCII hex streamer: ASCII constants,
// FSM state encodings and the nibble-to-character helper.
package mesa_word2ascii_pkg;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] HEX_UC_OFS = 8'h37;
    localparam logic [7:0] HEX_LC_OFS = 8'h57;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        NIB       = 3'd2,
        WAIT_IDLE = 3'd3,
        EOL_CR    = 3'd4,
        EOL_LF    = 3'd5
    } state_t;

    // Offsets are chosen so that ofs + nibble lands on '0'..'9', 'A'..'F' or 'a'..'f'.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic lower);
        logic [7:0] ofs;
        if (nib < 4'd10) begin
            ofs = ASCII_0;
        end else if (lower) begin
            ofs = HEX_LC_OFS;
        end else begin
            ofs = HEX_UC_OFS;
        end
        return ofs + {4'h0, nib};
    endfunction

endpackage

// File: rtl/mesa_word2ascii_if.sv
// Word-side and character-side signals of the hex streamer, with the
// streamer as slave and the surrounding logic (host + UART) as master.
interface mesa_word2ascii_if #(
    parameter int BYTES_PER_WORD = 4
);
    logic                        no_handshake;
    logic                        hex_lower;
    logic [8*BYTES_PER_WORD-1:0] tx_word_d;
    logic                        tx_word_en;
    logic                        tx_word_done;
    logic                        tx_word_busy;
    logic                        tx_overflow;
    logic [7:0]                  tx_char_d;
    logic                        tx_char_en;
    logic                        tx_char_busy;
    logic                        tx_char_idle;

    modport master (
        output no_handshake, hex_lower, tx_word_d, tx_word_en, tx_word_done,
               tx_char_busy, tx_char_idle,
        input  tx_word_busy, tx_overflow, tx_char_d, tx_char_en
    );

    modport slave (
        input  no_handshake, hex_lower, tx_word_d, tx_word_en, tx_word_done,
               tx_char_busy, tx_char_idle,
        output tx_word_busy, tx_overflow, tx_char_d, tx_char_en
    );
endinterface

// File: rtl/mesa_tx_fifo.sv
// Small synchronous FIFO with fall-through read data; a write while full is
// taken only when a pop happens in the same cycle, otherwise it is dropped.
module mesa_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             wr_drop
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign wr_drop = wr_en && !wr_ok;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/mesa_word2ascii.sv
// Streams queued binary words to a byte UART as ASCII hex, MS nibble first,
// with an optional "\n" or "\r\n" terminator per entry.
//
// state     | meaning
// IDLE      | waiting for a FIFO entry and an open send slot; pops it and
//           | emits the first nibble of a data entry directly
// LOAD      | terminator-only entry latched, dispatch to line-end handling
// NIB       | emitting remaining nibbles, one per send slot
// WAIT_IDLE | terminator pending, waiting for the UART shifter to drain
// EOL_CR    | emit carriage return
// EOL_LF    | emit line feed
module mesa_word2ascii
    import mesa_word2ascii_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int EOL_CRLF       = 0
) (
    input logic              clk,
    input logic              reset,
    mesa_word2ascii_if.slave bus
);
    localparam int            WW   = 8 * BYTES_PER_WORD;
    localparam int            EW   = WW + 2;
    localparam logic [3:0]    NIBS = 4'(2 * BYTES_PER_WORD);
    localparam state_t        EOL_FIRST = (EOL_CRLF != 0) ? EOL_CR : EOL_LF;

    logic [EW-1:0] fifo_wr_data;
    logic [EW-1:0] fifo_rd_data;
    logic          fifo_wr;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;

    logic [WW-1:0] head_word;
    logic          head_data;
    logic          head_done;

    state_t        state, state_nxt;
    logic [WW-1:0] word_q, word_nxt;
    logic          done_q, done_nxt;
    logic [3:0]    cnt_q, cnt_nxt;
    logic [7:0]    char_q, char_nxt;
    logic          en_q, en_nxt;
    logic          en_d1;
    logic          ovf_q;
    logic          slot;

    // Entry layout: {has data, terminator requested, word}.
    assign fifo_wr      = bus.tx_word_en || bus.tx_word_done;
    assign fifo_wr_data = {bus.tx_word_en, bus.tx_word_done, bus.tx_word_d};
    assign {head_data, head_done, head_word} = fifo_rd_data;

    mesa_tx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_drop (fifo_drop)
    );

    // Two quiet cycles after each strobe give the UART time to raise busy.
    assign slot = bus.no_handshake || (!bus.tx_char_busy && !en_q && !en_d1);

    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        done_nxt  = done_q;
        cnt_nxt   = cnt_q;
        char_nxt  = char_q;
        en_nxt    = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && slot) begin
                    fifo_pop = 1'b1;
                    done_nxt = head_done;
                    if (head_data) begin
                        char_nxt  = nib2ascii(head_word[WW-1 -: 4], bus.hex_lower);
                        en_nxt    = 1'b1;
                        word_nxt  = head_word << 4;
                        cnt_nxt   = NIBS - 4'd1;
                        state_nxt = NIB;
                    end else begin
                        word_nxt  = head_word;
                        cnt_nxt   = 4'd0;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = bus.no_handshake ? EOL_FIRST : WAIT_IDLE;
                end else begin
                    state_nxt = NIB;
                end
            end
            NIB: begin
                if (slot) begin
                    char_nxt = nib2ascii(word_q[WW-1 -: 4], bus.hex_lower);
                    en_nxt   = 1'b1;
                    word_nxt = word_q << 4;
                    cnt_nxt  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (done_q) begin
                            state_nxt = bus.no_handshake ? EOL_FIRST : WAIT_IDLE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (bus.no_handshake || bus.tx_char_idle) state_nxt = EOL_FIRST;
            end
            EOL_CR: begin
                if (slot) begin
                    char_nxt  = ASCII_CR;
                    en_nxt    = 1'b1;
                    state_nxt = EOL_LF;
                end
            end
            EOL_LF: begin
                if (slot) begin
                    char_nxt  = ASCII_LF;
                    en_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            word_q <= '0;
            done_q <= 1'b0;
            cnt_q  <= 4'd0;
            char_q <= 8'h00;
            en_q   <= 1'b0;
            en_d1  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            done_q <= done_nxt;
            cnt_q  <= cnt_nxt;
            char_q <= char_nxt;
            en_q   <= en_nxt;
            en_d1  <= en_q;
            if (fifo_drop) ovf_q <= 1'b1;
        end
    end

    assign bus.tx_char_d    = char_q;
    assign bus.tx_char_en   = en_q;
    assign bus.tx_word_busy = fifo_full;
    assign bus.tx_overflow  = ovf_q;
endmodule

// File: tb/tb_mesa_word2ascii.sv
// Bench for the hex streamer: two instances (16-bit/LF and 32-bit/CRLF)
// fed from stimulus tasks, characters checked against a scoreboard queue.
module tb_mesa_word2ascii;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mesa_word2ascii_if #(.BYTES_PER_WORD(2)) bus_a ();
    mesa_word2ascii_if #(.BYTES_PER_WORD(4)) bus_b ();

    mesa_word2ascii #(.BYTES_PER_WORD(2), .FIFO_DEPTH(4), .EOL_CRLF(0)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a)
    );
    mesa_word2ascii #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4), .EOL_CRLF(1)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b)
    );

    // UART stand-in: busy for a few cycles after each strobe.
    int   ucnt_a = 0, ucnt_b = 0;
    logic force_busy_a = 1'b0, hold_idle_b = 1'b0;
    assign bus_a.tx_char_busy = force_busy_a || (ucnt_a != 0);
    assign bus_a.tx_char_idle = !bus_a.tx_char_busy;
    assign bus_b.tx_char_busy = (ucnt_b != 0);
    assign bus_b.tx_char_idle = !bus_b.tx_char_busy && !hold_idle_b;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         cyc_a[$];
    int         cyc_b[$];
    int         last_a = 0, last_b = 0;
    bit         hs_prev_a = 1'b0, hs_prev_b = 1'b0;
    logic [15:0] w5 [5];
    int         w_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        if (bus_a.tx_char_en) begin
            cyc_a.push_back(cyc);
            if (exp_a.size() == 0) begin
                chk("a_extra_char", 32'(bus_a.tx_char_d), 32'h100);
            end else begin
                e = exp_a.pop_front();
                chk("a_char", 32'(bus_a.tx_char_d), 32'(e));
            end
            if (!bus_a.no_handshake && hs_prev_a) chk("a_gap_ge3", 32'((cyc - last_a) >= 3), 32'd1);
            last_a    = cyc;
            hs_prev_a = !bus_a.no_handshake;
            ucnt_a    = 5;
        end else if (ucnt_a > 0) begin
            ucnt_a--;
        end
        if (bus_b.tx_char_en) begin
            cyc_b.push_back(cyc);
            if (exp_b.size() == 0) begin
                chk("b_extra_char", 32'(bus_b.tx_char_d), 32'h100);
            end else begin
                e = exp_b.pop_front();
                chk("b_char", 32'(bus_b.tx_char_d), 32'(e));
            end
            if (!bus_b.no_handshake && hs_prev_b) chk("b_gap_ge3", 32'((cyc - last_b) >= 3), 32'd1);
            last_b    = cyc;
            hs_prev_b = !bus_b.no_handshake;
            ucnt_b    = 5;
        end else if (ucnt_b > 0) begin
            ucnt_b--;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [15:0] w, input logic en, input logic done);
        bus_a.tx_word_d = w; bus_a.tx_word_en = en; bus_a.tx_word_done = done;
        w_cyc = cyc;
        @(posedge clk); #1;
        bus_a.tx_word_en = 1'b0; bus_a.tx_word_done = 1'b0;
    endtask

    task automatic wr_b(input logic [31:0] w, input logic en, input logic done);
        bus_b.tx_word_d = w; bus_b.tx_word_en = en; bus_b.tx_word_done = done;
        w_cyc = cyc;
        @(posedge clk); #1;
        bus_b.tx_word_en = 1'b0; bus_b.tx_word_done = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] w, input bit done, input bit lower);
        for (int i = 3; i >= 0; i--) exp_a.push_back(hexc(w[i*4 +: 4], lower));
        if (done) exp_a.push_back(8'h0A);
    endtask

    task automatic push_b(input logic [31:0] w, input bit done, input bit lower);
        for (int i = 7; i >= 0; i--) exp_b.push_back(hexc(w[i*4 +: 4], lower));
        if (done) begin
            exp_b.push_back(8'h0D);
            exp_b.push_back(8'h0A);
        end
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1;
        bus_a.no_handshake = 1'b1; bus_a.hex_lower = 1'b0;
        bus_a.tx_word_d = '0; bus_a.tx_word_en = 1'b0; bus_a.tx_word_done = 1'b0;
        bus_b.no_handshake = 1'b0; bus_b.hex_lower = 1'b1;
        bus_b.tx_word_d = '0; bus_b.tx_word_en = 1'b0; bus_b.tx_word_done = 1'b0;
        w5[0] = 16'h0123; w5[1] = 16'h4567; w5[2] = 16'h89AB; w5[3] = 16'hCDEF; w5[4] = 16'hFFFF;
        wait_cycles(3);
        chk("a_rst_en",   32'(bus_a.tx_char_en),   32'd0);
        chk("a_rst_d",    32'(bus_a.tx_char_d),    32'd0);
        chk("a_rst_busy", 32'(bus_a.tx_word_busy), 32'd0);
        chk("a_rst_ovf",  32'(bus_a.tx_overflow),  32'd0);
        chk("b_rst_en",   32'(bus_b.tx_char_en),   32'd0);
        chk("b_rst_d",    32'(bus_b.tx_char_d),    32'd0);
        reset = 1'b0;
        wait_cycles(3);

        // 0x1AF3 + LF, streaming mode, one char per cycle
        base = cyc_a.size();
        push_a(16'h1AF3, 1'b1, 1'b0);
        wr_a(16'h1AF3, 1'b1, 1'b1);
        wait_cycles(12);
        chk("a_nchars_1af3", 32'(cyc_a.size() - base), 32'd5);
        if (cyc_a.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) chk("a_cyc_1af3", 32'(cyc_a[base+i]), 32'(w_cyc + 2 + i));
        end
        chk("a_hold_d", 32'(bus_a.tx_char_d), 32'h0A);

        // terminator-only entry
        base = cyc_a.size();
        exp_a.push_back(8'h0A);
        wr_a(16'h0000, 1'b0, 1'b1);
        wait_cycles(10);
        chk("a_nchars_done_only", 32'(cyc_a.size() - base), 32'd1);

        // 0xDEADBEEF lower-case, CRLF held back until the UART goes idle
        hold_idle_b = 1'b1;
        base = cyc_b.size();
        push_b(32'hDEADBEEF, 1'b1, 1'b1);
        wr_b(32'hDEADBEEF, 1'b1, 1'b1);
        n = 0;
        while (cyc_b.size() < base + 8 && n < 200) begin
            wait_cycles(1);
            n++;
        end
        chk("b_nchars_hex", 32'(cyc_b.size() - base), 32'd8);
        if (cyc_b.size() > base) chk("b_first_latency", 32'(cyc_b[base] - w_cyc), 32'd2);
        wait_cycles(20);
        chk("b_no_cr_while_busy", 32'(cyc_b.size() - base), 32'd8);
        hold_idle_b = 1'b0;
        wait_cycles(40);
        chk("b_nchars_crlf", 32'(cyc_b.size() - base), 32'd10);

        // terminator-only on the CRLF instance
        base = cyc_b.size();
        exp_b.push_back(8'h0D); exp_b.push_back(8'h0A);
        wr_b(32'h0, 1'b0, 1'b1);
        wait_cycles(40);
        chk("b_nchars_done_only", 32'(cyc_b.size() - base), 32'd2);

        // handshake mode, UART busy for 10 cycles
        bus_a.no_handshake = 1'b0;
        force_busy_a = 1'b1;
        base = cyc_a.size();
        push_a(16'h9C05, 1'b0, 1'b0);
        wr_a(16'h9C05, 1'b1, 1'b0);
        wait_cycles(10);
        chk("a_quiet_while_busy", 32'(cyc_a.size() - base), 32'd0);
        force_busy_a = 1'b0;
        wait_cycles(60);
        chk("a_nchars_9c05", 32'(cyc_a.size() - base), 32'd4);

        // fill the FIFO while blocked; fifth write must be dropped
        force_busy_a = 1'b1;
        chk("a_ovf_pre", 32'(bus_a.tx_overflow), 32'd0);
        for (int i = 0; i < 4; i++) push_a(w5[i], 1'b0, 1'b0);
        base = cyc_a.size();
        for (int i = 0; i < 5; i++) begin
            bus_a.tx_word_d = w5[i]; bus_a.tx_word_en = 1'b1;
            if (i == 3) chk("a_busy_after3", 32'(bus_a.tx_word_busy), 32'd0);
            if (i == 4) chk("a_busy_after4", 32'(bus_a.tx_word_busy), 32'd1);
            @(posedge clk); #1;
        end
        bus_a.tx_word_en = 1'b0;
        chk("a_ovf_set", 32'(bus_a.tx_overflow), 32'd1);
        wait_cycles(5);
        chk("a_ovf_sticky", 32'(bus_a.tx_overflow), 32'd1);
        force_busy_a = 1'b0;
        wait_cycles(150);
        chk("a_nchars_fill", 32'(cyc_a.size() - base), 32'd16);
        chk("a_ovf_after_drain", 32'(bus_a.tx_overflow), 32'd1);
        chk("a_busy_after_drain", 32'(bus_a.tx_word_busy), 32'd0);

        // reset after third char of 0x12345678
        bus_b.no_handshake = 1'b1;
        base = cyc_b.size();
        exp_b.push_back(8'h31); exp_b.push_back(8'h32); exp_b.push_back(8'h33);
        wr_b(32'h12345678, 1'b1, 1'b0);
        n = 0;
        while (cyc_b.size() < base + 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("b_nchars_pre_reset", 32'(cyc_b.size() - base), 32'd3);
        reset = 1'b1;
        #1;
        chk("b_rst_en_mid", 32'(bus_b.tx_char_en),   32'd0);
        chk("b_rst_busy",   32'(bus_b.tx_word_busy), 32'd0);
        chk("b_rst_d_mid",  32'(bus_b.tx_char_d),    32'd0);
        chk("a_ovf_cleared", 32'(bus_a.tx_overflow), 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(30);
        chk("b_no_chars_after_reset", 32'(cyc_b.size() - base), 32'd3);

        chk("a_pending", 32'(exp_a.size()), 32'd0);
        chk("b_pending", 32'(exp_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
